// File: rtl/rd_arb.sv
// rd_arb: round-robin arbiter in front of a shared read engine.
// One requester at a time is granted; the arbiter pulses go to start the
// engine, waits for the engine data strobe, then pulses done to the winner.
// Optional build macro: RD_ARB_TIMEOUT_EN adds a BUSY-cycle watchdog that
// aborts a stalled transaction with a one-cycle err pulse.
module rd_arb #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_gnt,
    output logic [N_REQ-1:0] o_done,
    output logic             o_err,
    output logic             o_go,
    input  logic             i_ds,
    output logic             o_busy
);

    localparam int               PW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PW-1:0]    PTR_LAST = PW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    // Out-of-range parameters leave a visible marker in the elaborated hierarchy.
    if ((N_REQ < 2) || (N_REQ > 8) || (TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_param_out_of_range
    end

    state_t           r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_done;
    logic             r_go;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_win;

    logic             w_found;
    logic [PW-1:0]    w_win;
    logic [PW-1:0]    w_sel;
    int               w_idx;

    // Round-robin search: first set request starting one past the last winner, with wrap.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_sel   = r_ptr;
        w_idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end else begin
                w_idx = w_idx;
            end
            w_sel = PW'(w_idx);
            if (!w_found && i_req[w_sel]) begin
                w_found = 1'b1;
                w_win   = w_sel;
            end else begin
                w_found = w_found;
            end
        end
    end

`ifdef RD_ARB_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic       r_err;
    logic [7:0] r_cnt;

    // Arbiter FSM with watchdog: grant, start pulse, completion or abort, pointer update.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= {N_REQ{1'b0}};
            r_done  <= {N_REQ{1'b0}};
            r_go    <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= 8'd0;
            r_ptr   <= PTR_LAST;
            r_win   <= PTR_LAST;
        end else begin
            r_go   <= 1'b0;
            r_done <= {N_REQ{1'b0}};
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= ONE_HOT0 << w_win;
                        r_win   <= w_win;
                        r_go    <= 1'b1;
                        r_state <= ST_GRANT;
                    end else begin
                        r_gnt   <= {N_REQ{1'b0}};
                    end
                end
                ST_GRANT: begin
                    r_cnt   <= 8'd0;
                    r_state <= ST_BUSY;
                end
                ST_BUSY: begin
                    // Data strobe takes precedence over a watchdog expiry in the same cycle.
                    if (i_ds) begin
                        r_done  <= r_gnt;
                        r_gnt   <= {N_REQ{1'b0}};
                        r_ptr   <= r_win;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_err   <= 1'b1;
                        r_gnt   <= {N_REQ{1'b0}};
                        r_ptr   <= r_win;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_gnt   <= {N_REQ{1'b0}};
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_err = r_err;
`else
    // Arbiter FSM: grant, start pulse, wait indefinitely for the strobe, pointer update.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= {N_REQ{1'b0}};
            r_done  <= {N_REQ{1'b0}};
            r_go    <= 1'b0;
            r_ptr   <= PTR_LAST;
            r_win   <= PTR_LAST;
        end else begin
            r_go   <= 1'b0;
            r_done <= {N_REQ{1'b0}};
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= ONE_HOT0 << w_win;
                        r_win   <= w_win;
                        r_go    <= 1'b1;
                        r_state <= ST_GRANT;
                    end else begin
                        r_gnt   <= {N_REQ{1'b0}};
                    end
                end
                ST_GRANT: begin
                    r_state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (i_ds) begin
                        r_done  <= r_gnt;
                        r_gnt   <= {N_REQ{1'b0}};
                        r_ptr   <= r_win;
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_BUSY;
                    end
                end
                default: begin
                    r_gnt   <= {N_REQ{1'b0}};
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_err = 1'b0;
`endif

    assign o_gnt  = r_gnt;
    assign o_done = r_done;
    assign o_go   = r_go;
    assign o_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rd_arb.sv
// tb_rd_arb: directed bench for rd_arb (N_REQ=4, TIMEOUT=16).
module tb_rd_arb;

    localparam int N  = 4;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         ds;
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic         err;
    logic         go;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int wt;
    bit seen;

    rd_arb #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .i_req   (req),
        .o_gnt   (gnt),
        .o_done  (done),
        .o_err   (err),
        .o_go    (go),
        .i_ds    (ds),
        .o_busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for go, check grant against the scoreboard, hold dly cycles, strobe ds, check done.
    task automatic serve(input int dly, input logic [N-1:0] req_busy,
                         input logic [N-1:0] req_post, output int waited);
        bit          got;
        int          w;
        logic [31:0] oh;
        got    = 1'b0;
        waited = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            waited++;
            if (go === 1'b1) begin
                got = 1'b1;
            end else begin
                chk("wait_no_done", 32'(done), 32'd0);
                chk("wait_no_err", 32'(err), 32'd0);
            end
        end
        chk("go_seen", 32'(got), 32'd1);
        if (!got) return;
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) return;
        w  = exp_q.pop_front();
        oh = 32'd1 << w;
        chk("gnt_winner", 32'(gnt), oh);
        chk("busy_in_grant", 32'(busy), 32'd1);
        req = req_busy;
        for (int c = 0; c < dly; c++) begin
            tick();
            chk("go_one_cycle", 32'(go), 32'd0);
            chk("gnt_held", 32'(gnt), oh);
            chk("no_early_done", 32'(done), 32'd0);
            chk("busy_held", 32'(busy), 32'd1);
        end
        ds  = 1'b1;
        req = req_post;
        tick();
        ds  = 1'b0;
        chk("done_pulse", 32'(done), oh);
        chk("gnt_cleared", 32'(gnt), 32'd0);
        chk("no_err_on_done", 32'(err), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        ds  = 1'b0;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_go", 32'(go), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // All four requesting: rotation 0,1,2,3,0
        req = 4'b1111;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        serve(3, 4'b1111, 4'b1111, wt);
        serve(3, 4'b1111, 4'b1111, wt);
        chk("rr_back_to_back", 32'(wt), 32'd1);
        serve(3, 4'b1111, 4'b1111, wt);
        serve(3, 4'b1111, 4'b1111, wt);
        serve(3, 4'b1111, 4'b0000, wt);
        tick();
        chk("quiet_go", 32'(go), 32'd0);
        chk("quiet_busy", 32'(busy), 32'd0);
        chk("quiet_gnt", 32'(gnt), 32'd0);

        // Lone requester 2 is re-granted two cycles after ds
        req = 4'b0100;
        exp_q.push_back(2);
        serve(2, 4'b0100, 4'b0100, wt);
        exp_q.push_back(2);
        serve(2, 4'b0100, 4'b0000, wt);
        chk("regrant_two_cycles", 32'(wt), 32'd1);

        // Requester 1 drops req while busy: still completes
        req = 4'b0010;
        exp_q.push_back(1);
        serve(4, 4'b0000, 4'b0000, wt);

        // Fairness: pointer at 1, req 0 and 1 -> 0 then 1
        req = 4'b0011;
        exp_q.push_back(0);
        exp_q.push_back(1);
        serve(1, 4'b0011, 4'b0011, wt);
        serve(1, 4'b0011, 4'b0000, wt);

        // Stray ds in IDLE
        tick();
        ds = 1'b1;
        tick();
        ds = 1'b0;
        chk("stray_done", 32'(done), 32'd0);
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_go", 32'(go), 32'd0);
        tick();
        chk("stray_done2", 32'(done), 32'd0);
        chk("stray_busy2", 32'(busy), 32'd0);

        // Reset during BUSY of requester 2
        req  = 4'b1111;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (go === 1'b1) seen = 1'b1;
        end
        chk("mid_go_seen", 32'(seen), 32'd1);
        chk("mid_gnt2", 32'(gnt), 32'h4);
        tick();
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_gnt", 32'(gnt), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        tick();
        chk("async_done", 32'(done), 32'd0);
        chk("async_err", 32'(err), 32'd0);
        rst = 1'b0;
        exp_q.push_back(0);
        serve(3, 4'b1111, 4'b0000, wt);

`ifdef RD_ARB_TIMEOUT_EN
        // Watchdog abort after TO busy cycles, then ds exactly on the last cycle
        req  = 4'b0011;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (go === 1'b1) seen = 1'b1;
        end
        chk("to_go_seen", 32'(seen), 32'd1);
        chk("to_gnt1", 32'(gnt), 32'h2);
        for (int c = 0; c < TO; c++) begin
            tick();
            chk("to_no_err_yet", 32'(err), 32'd0);
            chk("to_gnt_held", 32'(gnt), 32'h2);
        end
        tick();
        chk("to_err_pulse", 32'(err), 32'd1);
        chk("to_no_done", 32'(done), 32'd0);
        chk("to_gnt_clear", 32'(gnt), 32'd0);
        chk("to_busy_idle", 32'(busy), 32'd0);
        exp_q.push_back(0);
        serve(TO, 4'b0011, 4'b0000, wt);
        chk("to_next_grant", 32'(wt), 32'd1);
        tick();
        chk("to_err_single", 32'(err), 32'd0);
`else
        // No watchdog: BUSY waits well past TIMEOUT for ds
        req = 4'b0010;
        exp_q.push_back(1);
        serve(3 * TO, 4'b0010, 4'b0000, wt);
        tick();
        chk("nto_err_zero", 32'(err), 32'd0);
`endif

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
